// File: rtl/player_attack_multi.sv
// player_attack_multi
//   Multi-type attack sequencer for one fighter. Each attack type has its own
//   startup, active and recovery frame counts and its own horizontal reach.
//   While the attack is ACTIVE, the block places a facing-aware hitbox and tests
//   it against the opponent's body box. It raises a single hit pulse per attack.
//   The block runs on the pixel clock. All state advances on the per-frame SCEN
//   tick; the one exception is clearing of hit_pulse.
//
// Optional feature (macro ATK_BUFFER_EN):
//   When defined, a one-deep buffer holds the first request edge seen during
//   RECOVERY. That attack then starts with no IDLE frame in between.
//   When undefined, edges seen during RECOVERY are dropped.
//
// Ports:
//   clk            pixel clock
//   reset          synchronous, active-high
//   SCEN           one-clk frame tick
//   attack_enable  low cancels a running attack or inhibits a new one
//   attack_req     level requests, bit i selects type i+1
//   pos_x, pos_y   player top-left corner
//   facing_right   1 = hitbox placed to the right of the player
//   opp_x, opp_y   opponent top-left corner
//   attack_active  phase is ACTIVE
//   attack_busy    phase is not IDLE
//   attack_type    current type, 1-based, 0 when idle
//   phase          0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
//   hb_x .. hb_h   hitbox, all zero outside ACTIVE
//   hit_pulse      one-clk pulse when a hit lands
//   hit_type       type of the last landed hit
module player_attack_multi #(
    parameter int NUM_ATK = 4,
    parameter int DUR_W   = 6,
    parameter logic [NUM_ATK*DUR_W-1:0] STARTUP_F = {6'd6, 6'd4, 6'd3, 6'd2},
    parameter logic [NUM_ATK*DUR_W-1:0] ACTIVE_F  = {6'd6, 6'd5, 6'd4, 6'd3},
    parameter logic [NUM_ATK*DUR_W-1:0] RECOV_F   = {6'd8, 6'd6, 6'd5, 6'd4},
    parameter logic [NUM_ATK*10-1:0]    REACH     = {10'd120, 10'd90, 10'd60, 10'd30},
    parameter int BOX_W = 60,
    parameter int BOX_H = 60,
    localparam int TYPE_W = $clog2(NUM_ATK + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SCEN,
    input  logic               attack_enable,
    input  logic [NUM_ATK-1:0] attack_req,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               facing_right,
    input  logic [9:0]         opp_x,
    input  logic [9:0]         opp_y,
    output logic               attack_active,
    output logic               attack_busy,
    output logic [TYPE_W-1:0]  attack_type,
    output logic [1:0]         phase,
    output logic [9:0]         hb_x,
    output logic [9:0]         hb_y,
    output logic [9:0]         hb_w,
    output logic [9:0]         hb_h,
    output logic               hit_pulse,
    output logic [TYPE_W-1:0]  hit_type
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STARTUP  = 2'd1,
        ACTIVE   = 2'd2,
        RECOVERY = 2'd3
    } phase_t;

    phase_t              state, state_nxt;
    logic [DUR_W-1:0]    cnt, cnt_nxt;
    logic [TYPE_W-1:0]   type_q, type_nxt;
    logic [NUM_ATK-1:0]  req_prev, req_prev_nxt;
    logic                hit_latch, hit_latch_nxt;
    logic                hit_pulse_nxt;
    logic [TYPE_W-1:0]   hit_type_nxt;
    logic [NUM_ATK-1:0]  rise;
    logic                rise_any;
    logic [TYPE_W-1:0]   rise_type;
    logic [9:0]          reach;
    logic [10:0]         hbx_i, hbw_i;
    logic                overlap;
`ifdef ATK_BUFFER_EN
    logic                buf_valid, buf_valid_nxt;
    logic [TYPE_W-1:0]   buf_type, buf_type_nxt;
`endif

    // Look up a per-type frame count for a 1-based type. A zero field still
    // has to last one frame, so zero is promoted to one.
    function automatic logic [DUR_W-1:0] pick_dur(input logic [NUM_ATK*DUR_W-1:0] f,
                                                  input logic [TYPE_W-1:0] t);
        logic [DUR_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_ATK; i++)
            if (t == TYPE_W'(i + 1)) d = f[i*DUR_W +: DUR_W];
        if (d == '0) d = DUR_W'(1);
        return d;
    endfunction

    // Find rising request edges and pick the lowest-index one. The loop runs
    // downward, so the lowest set bit is the last to assign and wins.
    always_comb begin
        rise      = attack_req & ~req_prev;
        rise_any  = |rise;
        rise_type = '0;
        for (int i = NUM_ATK - 1; i >= 0; i--)
            if (rise[i]) rise_type = TYPE_W'(i + 1);
    end

    // Build the hitbox from the current phase and the player's position.
    // The math is 11 bits wide, so the right-facing box never wraps. The
    // left-facing box is clamped at the screen edge.
    always_comb begin
        reach = '0;
        for (int i = 0; i < NUM_ATK; i++)
            if (type_q == TYPE_W'(i + 1)) reach = REACH[i*10 +: 10];
        hbx_i = '0;
        hbw_i = '0;
        hb_y  = '0;
        hb_h  = '0;
        if (state == ACTIVE) begin
            hb_y = pos_y;
            hb_h = 10'(BOX_H);
            if (facing_right) begin
                hbx_i = {1'b0, pos_x} + 11'(BOX_W);
                hbw_i = {1'b0, reach};
            end else if (pos_x < reach) begin
                hbx_i = '0;
                hbw_i = {1'b0, pos_x};
            end else begin
                hbx_i = {1'b0, pos_x} - {1'b0, reach};
                hbw_i = {1'b0, reach};
            end
        end
        hb_x = hbx_i[9:0];
        hb_w = hbw_i[9:0];
        // Strict inequalities: boxes that only touch edges do not overlap.
        overlap = (hbw_i != '0) &&
                  ({1'b0, hbx_i} < ({2'b0, opp_x} + 12'(BOX_W))) &&
                  ({2'b0, opp_x} < ({1'b0, hbx_i} + {1'b0, hbw_i})) &&
                  ({2'b0, hb_y}  < ({2'b0, opp_y} + 12'(BOX_H))) &&
                  ({2'b0, opp_y} < ({2'b0, hb_y} + {2'b0, hb_h}));
    end

    // Next-state logic for the phase sequencer, the hit latch and the request
    // history. Everything holds between frame ticks, except hit_pulse,
    // which clears on the next clk.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        type_nxt      = type_q;
        req_prev_nxt  = req_prev;
        hit_latch_nxt = hit_latch;
        hit_pulse_nxt = 1'b0;
        hit_type_nxt  = hit_type;
`ifdef ATK_BUFFER_EN
        buf_valid_nxt = buf_valid;
        buf_type_nxt  = buf_type;
`endif
        if (SCEN) begin
            req_prev_nxt = attack_req;
            // A hit lands at most once per attack. A frame that aborts the
            // attack never scores.
            if (state == ACTIVE && attack_enable && overlap && !hit_latch) begin
                hit_pulse_nxt = 1'b1;
                hit_type_nxt  = type_q;
                hit_latch_nxt = 1'b1;
            end
            if (state == IDLE) begin
                if (attack_enable && rise_any) begin
                    state_nxt     = STARTUP;
                    type_nxt      = rise_type;
                    cnt_nxt       = pick_dur(STARTUP_F, rise_type);
                    hit_latch_nxt = 1'b0;
                end
            end else if (!attack_enable) begin
                state_nxt = IDLE;
                type_nxt  = '0;
                cnt_nxt   = '0;
`ifdef ATK_BUFFER_EN
                buf_valid_nxt = 1'b0;
`endif
            end else if (cnt > DUR_W'(1)) begin
                cnt_nxt = cnt - DUR_W'(1);
`ifdef ATK_BUFFER_EN
                if (state == RECOVERY && !buf_valid && rise_any) begin
                    buf_valid_nxt = 1'b1;
                    buf_type_nxt  = rise_type;
                end
`endif
            end else if (state == STARTUP) begin
                state_nxt = ACTIVE;
                cnt_nxt   = pick_dur(ACTIVE_F, type_q);
            end else if (state == ACTIVE) begin
                state_nxt = RECOVERY;
                cnt_nxt   = pick_dur(RECOV_F, type_q);
            end else begin
`ifdef ATK_BUFFER_EN
                // A press on this final RECOVERY tick still counts as seen
                // during RECOVERY.
                if (buf_valid || rise_any) begin
                    state_nxt     = STARTUP;
                    type_nxt      = buf_valid ? buf_type : rise_type;
                    cnt_nxt       = pick_dur(STARTUP_F, buf_valid ? buf_type : rise_type);
                    hit_latch_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                    type_nxt  = '0;
                    cnt_nxt   = '0;
                end
                buf_valid_nxt = 1'b0;
`else
                state_nxt = IDLE;
                type_nxt  = '0;
                cnt_nxt   = '0;
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            type_q    <= '0;
            req_prev  <= '0;
            hit_latch <= 1'b0;
            hit_pulse <= 1'b0;
            hit_type  <= '0;
`ifdef ATK_BUFFER_EN
            buf_valid <= 1'b0;
            buf_type  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            type_q    <= type_nxt;
            req_prev  <= req_prev_nxt;
            hit_latch <= hit_latch_nxt;
            hit_pulse <= hit_pulse_nxt;
            hit_type  <= hit_type_nxt;
`ifdef ATK_BUFFER_EN
            buf_valid <= buf_valid_nxt;
            buf_type  <= buf_type_nxt;
`endif
        end
    end

    assign attack_active = (state == ACTIVE);
    assign attack_busy   = (state != IDLE);
    assign attack_type   = type_q;
    assign phase         = state;

endmodule
